anita4_trig_pulse_gen: RTL
==========================

// Module: anita4_trig_pulse_gen
// PURPOSE
//  Transmit end of the single-pol trigger line. Turns a CLK-domain hit into one active-low TRIG pulse
//  of programmable width, then waits for the receiver's clear (ACK) and a holdoff before re-arming.
//  Sits on the trigger-source side of the single-pol trigger link. Its falling TRIG edge is what the
//  receiver latches. The receiver's CLR is returned here as ACK. Also counts emitted and lost triggers.
// PARAMETERS
//  PW_BITS      8    width of PULSE_WIDTH input
//  HO_BITS      12   width of HOLDOFF input
//  ACK_TIMEOUT  255  max cycles spent in WAIT_ACK before forced exit
//  CNT_BITS     16   width of TRIG_COUNT / LOST_COUNT
// PORTS
//  CLK          in   1         system clock; all logic on posedge
//  RST_N        in   1         asynchronous active-low reset
//  EN           in   1         arm enable; gates new pulse starts only
//  HIT          in   1         trigger request, level; rising edge detected internally
//  PULSE_WIDTH  in   PW_BITS   TRIG low time in cycles, 0 treated as 1
//  HOLDOFF      in   HO_BITS   dead cycles after ACK/timeout before re-arm
//  ACK          in   1         clear returned by receiver, CLK-synchronous level
//  COUNT_CLR    in   1         synchronous clear of counters and TIMEOUT
//  TRIG         out  1         trigger line, idle high, registered (IOB)
//  BUSY         out  1         high in any state other than IDLE
//  TIMEOUT      out  1         sticky: a WAIT_ACK timeout occurred
//  TRIG_COUNT   out  CNT_BITS  pulses emitted, saturating
//  LOST_COUNT   out  CNT_BITS  HIT rising edges ignored (busy or EN low), saturating
// BEHAVIOUR
//  - Reset (async, RST_N=0): TRIG=1, BUSY=0, TIMEOUT=0, counts=0, state=IDLE, hit_d=0.
//    Reset mid-pulse releases TRIG high immediately.
//  - hit_rise = HIT & ~hit_d. hit_d is registered every cycle in every state.
//  - IDLE: hit_rise & EN at edge k -> at edge k: state=PULSE, TRIG=0, width latched, TRIG_COUNT+1.
//    This is a 1-edge latency from HIT sampled high to TRIG low.
//  - PULSE: TRIG low for exactly max(PULSE_WIDTH,1) cycles (latched value), then TRIG=1 -> WAIT_ACK.
//    If ACK is high during PULSE, it is remembered (ack_seen).
//  - WAIT_ACK: the first cycle with ACK high (or ack_seen set) goes to HOLDOFF. After ACK_TIMEOUT
//    cycles without ACK -> TIMEOUT=1 and go to HOLDOFF.
//  - HOLDOFF: latch HOLDOFF on entry and count that many cycles -> IDLE. HOLDOFF=0 goes to IDLE on
//    the next edge.
//  - hit_rise while not in IDLE, or in IDLE with EN=0: LOST_COUNT+1 and no pulse.
//  - hit_rise on the same edge IDLE is re-entered: ignored and counted lost. Re-arm is effective
//    the cycle after IDLE is reached.
//  - EN falling mid-cycle does not abort the pulse, ACK wait or holdoff.
//  - Counters saturate at all-ones. COUNT_CLR beats a same-cycle increment (result 0).
//    COUNT_CLR also clears TIMEOUT. A same-cycle timeout with COUNT_CLR leaves TIMEOUT=1.
//  - PULSE_WIDTH/HOLDOFF changes mid-phase do not affect the current phase.
// STRUCTURE
//  - Shared header anita4_trig_defs.vh: state encodings (IDLE/PULSE/WAIT_ACK/HOLDOFF, 2-bit) and
//    default widths.
//  - One sub-module, anita4_sat_counter (CNT_BITS, inc, clr, async RST_N), instantiated twice.
//  - FSM, width/holdoff/timeout down-counters and the TRIG IOB flop live in the top.
// TESTING
//  1. PULSE_WIDTH=4, HOLDOFF=3, EN=1, HIT rise at edge 10, ACK high on edges 16-17 -> TRIG low
//     edges 10-13, high at 14; BUSY drops at edge 20; TRIG_COUNT=1.
//  2. PULSE_WIDTH=0 -> TRIG low exactly 1 cycle. HOLDOFF=0 with ACK during PULSE -> IDLE 2 edges
//     after TRIG rises.
//  3. ACK never asserted -> WAIT_ACK exits after 255 cycles, TIMEOUT=1. Then COUNT_CLR ->
//     TIMEOUT=0, counts=0.
//  4. 5 HIT edges during one BUSY period plus 2 with EN=0 -> TRIG_COUNT=1, LOST_COUNT=7.
//  5. RST_N low mid-PULSE -> TRIG=1 asynchronously, all outputs at reset values. A HIT after
//     release pulses normally.
//  6. Counters preloaded near saturation (CNT_BITS=4): 20 pulses -> TRIG_COUNT stays 15.
//     COUNT_CLR coincident with an increment -> 0.

Source files
------------

// File: rtl/anita4_trig_pulse_gen_pkg.sv
// Shared definitions for the single-pol trigger transmitter: FSM encoding and default widths.
package anita4_trig_pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_HOLDOFF  = 2'd3
   } trig_state_e;

   localparam int DEF_PW_BITS     = 8;
   localparam int DEF_HO_BITS     = 12;
   localparam int DEF_ACK_TIMEOUT = 255;
   localparam int DEF_CNT_BITS    = 16;

   // Bits needed to hold 0..n.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/anita4_trig_pulse_gen_sat_counter.sv
// Saturating event counter with synchronous clear that overrides a same-cycle increment.
module anita4_trig_pulse_gen_sat_counter #(
   parameter int CNT_BITS = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                inc_i,
   input  logic                clr_i,
   output logic [CNT_BITS-1:0] count_o
);

   logic [CNT_BITS-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {CNT_BITS{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/anita4_trig_pulse_gen.sv
// Trigger-line transmitter: one active-low TRIG pulse per accepted HIT edge, then ACK wait
// (with timeout) and holdoff before re-arming. Counts emitted and lost triggers.
module anita4_trig_pulse_gen
   import anita4_trig_pulse_gen_pkg::*;
#(
   parameter int PW_BITS     = DEF_PW_BITS,
   parameter int HO_BITS     = DEF_HO_BITS,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int CNT_BITS    = DEF_CNT_BITS
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                hit_i,
   input  logic [PW_BITS-1:0]  pulse_width_i,
   input  logic [HO_BITS-1:0]  holdoff_i,
   input  logic                ack_i,
   input  logic                count_clr_i,
   output logic                trig_o,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [CNT_BITS-1:0] trig_count_o,
   output logic [CNT_BITS-1:0] lost_count_o
);

   localparam int TO_BITS = cnt_width(ACK_TIMEOUT);
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(ACK_TIMEOUT - 1);

   trig_state_e        state_q, state_d;
   logic               trig_q, trig_d;
   logic               hit_prev_q;
   logic               ack_seen_q, ack_seen_d;
   logic               timeout_q, timeout_d;
   logic [PW_BITS-1:0] width_cnt_q, width_cnt_d;
   logic [HO_BITS-1:0] ho_cnt_q, ho_cnt_d;
   logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
   logic               hit_rise, start_pulse, lost_hit, to_fire;

   always_comb begin
      state_d     = state_q;
      trig_d      = trig_q;
      ack_seen_d  = ack_seen_q;
      width_cnt_d = width_cnt_q;
      ho_cnt_d    = ho_cnt_q;
      to_cnt_d    = to_cnt_q;
      start_pulse = 1'b0;
      to_fire     = 1'b0;
      hit_rise    = hit_i & ~hit_prev_q;

      case (state_q)
         ST_IDLE: begin
            if (hit_rise && en_i) begin
               start_pulse = 1'b1;
               state_d     = ST_PULSE;
               trig_d      = 1'b0;
               ack_seen_d  = 1'b0;
               // Remaining low cycles after this one; width 0 behaves as 1.
               width_cnt_d = (pulse_width_i == '0) ? '0 : pulse_width_i - 1'b1;
            end
         end
         ST_PULSE: begin
            if (ack_i) ack_seen_d = 1'b1;
            if (width_cnt_q == '0) begin
               trig_d   = 1'b1;
               state_d  = ST_WAIT_ACK;
               to_cnt_d = '0;
            end else begin
               width_cnt_d = width_cnt_q - 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            if (ack_i || ack_seen_q) begin
               state_d  = ST_HOLDOFF;
               ho_cnt_d = holdoff_i;
            end else if (to_cnt_q == TO_LAST) begin
               to_fire  = 1'b1;
               state_d  = ST_HOLDOFF;
               ho_cnt_d = holdoff_i;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (ho_cnt_q == '0) state_d = ST_IDLE;
            else                ho_cnt_d = ho_cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      lost_hit = hit_rise && !((state_q == ST_IDLE) && en_i);

      // A timeout raised this cycle survives a coincident clear.
      if (to_fire)          timeout_d = 1'b1;
      else if (count_clr_i) timeout_d = 1'b0;
      else                  timeout_d = timeout_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         trig_q      <= 1'b1;
         hit_prev_q  <= 1'b0;
         ack_seen_q  <= 1'b0;
         timeout_q   <= 1'b0;
         width_cnt_q <= '0;
         ho_cnt_q    <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_d;
         hit_prev_q  <= hit_i;
         ack_seen_q  <= ack_seen_d;
         timeout_q   <= timeout_d;
         width_cnt_q <= width_cnt_d;
         ho_cnt_q    <= ho_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   anita4_trig_pulse_gen_sat_counter #(.CNT_BITS(CNT_BITS)) u_trig_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (start_pulse),
      .clr_i   (count_clr_i),
      .count_o (trig_count_o)
   );

   anita4_trig_pulse_gen_sat_counter #(.CNT_BITS(CNT_BITS)) u_lost_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (lost_hit),
      .clr_i   (count_clr_i),
      .count_o (lost_count_o)
   );

   assign trig_o    = trig_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign timeout_o = timeout_q;

endmodule
